pipe_mem_arbiter: RTL

Arbitrates and sequences one single-ported, variable-latency memory shared by the IF stage (instruction fetch) and the MEM stage (load/store driven by the EXE/MEM register outputs). It runs a req/ack handshake to the memory and gives data accesses priority over fetches. It also generates the global pipeline stall that holds the PC and every pipeline register until both stages' accesses for the current cycle have completed.

---
 rtl/pipe_mem_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_mem_arbiter
//
// Shares one single-ported, variable-latency memory between the IF stage
// (instruction fetch) and the MEM stage (load/store). Data accesses take
// priority over fetches. The memory side uses a req/ack handshake. A global
// pipeline stall (pstall) holds the PC and every pipeline register until
// both stages have completed their access for the current pipeline cycle.
//
// Ports
//   clk        rising-edge clock
//   clrn       asynchronous active-low reset
//   if_req     IF stage wants a fetch this pipeline cycle
//   if_addr    fetch address (PC)
//   if_rdata   fetched instruction (registered, held until next fetch)
//   m_rd       MEM stage load
//   m_wr       MEM stage store (wins over m_rd when both are set)
//   m_addr     data address
//   m_wdata    store data
//   m_rdata    load data (registered, held until next load)
//   if_stall   fetch not yet complete
//   m_stall    data access not yet complete
//   pstall     global hold = if_stall | m_stall
//   mem_req    memory request (registered)
//   mem_we     memory write enable (registered)
//   mem_addr   memory address (registered)
//   mem_wdata  memory write data (registered)
//   mem_ack    memory completion, only meaningful while mem_req=1
//   mem_rdata  memory read data, valid with mem_ack
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access outstanding, mem_req low
// DATA  | load/store outstanding, waiting for mem_ack
// INST  | instruction fetch outstanding, waiting for mem_ack
// -----------------------------------------------------------------------------
module pipe_mem_arbiter (
    input  logic        clk,
    input  logic        clrn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    input  logic        m_rd,
    input  logic        m_wr,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic [31:0] m_rdata,
    output logic        if_stall,
    output logic        m_stall,
    output logic        pstall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Completion flags: this pipeline cycle's access already finished.
    logic        m_done;
    logic        if_done;

    logic        m_need;
    logic        if_need;

    logic        req_nxt;
    logic        we_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] wdata_nxt;

    logic        set_m_done;
    logic        set_if_done;
    logic        ld_m_rdata;
    logic        ld_if_rdata;

    // Stalls are purely combinational so they are valid even during reset.
    assign m_stall  = (m_rd | m_wr) & ~m_done;
    assign if_stall = if_req & ~if_done;
    assign pstall   = m_stall | if_stall;

    assign m_need   = m_stall;
    assign if_need  = if_stall;

    // -------------------------------------------------------------------------
    // Next-state and registered memory-port values
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        req_nxt     = mem_req;
        we_nxt      = mem_we;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_wdata;
        set_m_done  = 1'b0;
        set_if_done = 1'b0;
        ld_m_rdata  = 1'b0;
        ld_if_rdata = 1'b0;

        case (state)
            IDLE: begin
                // mem_ack is ignored here: nothing is outstanding.
                if (m_need) begin
                    state_nxt = DATA;
                    req_nxt   = 1'b1;
                    we_nxt    = m_wr;
                    addr_nxt  = m_addr;
                    wdata_nxt = m_wdata;
                end else if (if_need) begin
                    state_nxt = INST;
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b0;
                    addr_nxt  = if_addr;
                end else begin
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                end
            end

            DATA: begin
                if (mem_ack) begin
                    set_m_done = 1'b1;
                    // A combined rd+wr was issued as a write; do not load.
                    ld_m_rdata = m_rd & ~m_wr;
                    if (if_need) begin
                        // Back-to-back: mem_req stays high for the fetch.
                        state_nxt = INST;
                        req_nxt   = 1'b1;
                        we_nxt    = 1'b0;
                        addr_nxt  = if_addr;
                    end else begin
                        state_nxt = IDLE;
                        req_nxt   = 1'b0;
                        we_nxt    = 1'b0;
                    end
                end
            end

            INST: begin
                if (mem_ack) begin
                    set_if_done = 1'b1;
                    ld_if_rdata = 1'b1;
                    if (m_need) begin
                        state_nxt = DATA;
                        req_nxt   = 1'b1;
                        we_nxt    = m_wr;
                        addr_nxt  = m_addr;
                        wdata_nxt = m_wdata;
                    end else begin
                        state_nxt = IDLE;
                        req_nxt   = 1'b0;
                        we_nxt    = 1'b0;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
                we_nxt    = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and memory-port registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            state     <= state_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Completion flags. When pstall is low the pipeline advances this edge
    // and both flags clear; otherwise a finished access keeps its flag so it
    // is not re-issued while the other stage is still waiting.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_done  <= 1'b0;
            if_done <= 1'b0;
        end else if (!pstall) begin
            m_done  <= 1'b0;
            if_done <= 1'b0;
        end else begin
            if (set_m_done)
                m_done <= 1'b1;
            if (set_if_done)
                if_done <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Read-data registers, held until the next completion of their kind
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_rdata  <= 32'd0;
            if_rdata <= 32'd0;
        end else begin
            if (ld_m_rdata)
                m_rdata <= mem_rdata;
            if (ld_if_rdata)
                if_rdata <= mem_rdata;
        end
    end

endmodule
